// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Purpose  : Gray/binary conversion and pointer-step helpers for the gray link.
// Revision : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Ones in the low w bits; w = GRAY_MAX_W wraps to all ones.
  function automatic gray_word_t width_mask(input int w);
    return (gray_word_t'(1) << w) - gray_word_t'(1);
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b, input int w);
    gray_word_t bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g, input int w);
    gray_word_t b;
    logic       acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  // True when cur is prev or prev+1, modulo 2^w.
  function automatic logic step_ok(input gray_word_t prev, input gray_word_t cur,
                                   input int w);
    gray_word_t d;
    d = (cur - prev) & width_mask(w);
    return (d == gray_word_t'(0)) || (d == gray_word_t'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_ack_return_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_ack_return_if
// Purpose  : Pointer and consumer signals of the gray-ack return block.
// Revision : 1.0 - initial release
// ============================================================================
interface gray_ack_return_if #(parameter int WID = 4);

  logic [WID-1:0] din;
  logic           consume;
  logic [WID-1:0] dout;
  logic           avail;
  logic [WID-1:0] count;
  logic           taken;
  logic           underflow;
  logic           hazard;

  modport master (
    output din, consume,
    input  dout, avail, count, taken, underflow, hazard
  );

  modport slave (
    input  din, consume,
    output dout, avail, count, taken, underflow, hazard
  );

endinterface
`default_nettype wire

// File: rtl/gray_ack_decode.sv
`default_nettype none
// ============================================================================
// Module   : gray_ack_decode
// Purpose  : Decodes the synchronized gray write pointer and registers it;
//            optional step hazard check under GRAY_ACK_HAZARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gray_ack_decode
  import gray_pkg::*;
#(
  parameter int WID = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WID-1:0] din,
  output logic [WID-1:0] wbin,
  output logic           hazard
);

  logic [WID-1:0] wbin_d;
  logic [WID-1:0] wbin_q;

  always_comb begin
    wbin_d = WID'(gray2bin(gray_word_t'(din), WID));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbin_q <= '0;
    end else begin
      wbin_q <= wbin_d;
    end
  end

  assign wbin = wbin_q;

`ifdef GRAY_ACK_HAZARD_EN
  logic [WID-1:0] prev_d;
  logic [WID-1:0] prev_q;
  logic           hazard_d;
  logic           hazard_q;

  // The sample is kept even when flagged; the pulse is purely diagnostic.
  always_comb begin
    prev_d   = wbin_q;
    hazard_d = !step_ok(gray_word_t'(prev_q), gray_word_t'(wbin_q), WID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      hazard_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      hazard_q <= hazard_d;
    end
  end

  assign hazard = hazard_q;
`else
  assign hazard = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/gray_ack_return.sv
`default_nettype none
// ============================================================================
// Module   : gray_ack_return
// Purpose  : Receive-side pending-item tracker returning a registered gray
//            read pointer; hazard pulse enabled by GRAY_ACK_HAZARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gray_ack_return
  import gray_pkg::*;
#(
  parameter int WID = 4
) (
  input  logic              clk,
  input  logic              reset,
  gray_ack_return_if.slave  bus
);

  logic [WID-1:0] wbin;
  logic           hazard;
  logic [WID-1:0] count;
  logic           avail;
  logic           taken;
  logic [WID-1:0] rbin_d;
  logic [WID-1:0] rbin_q;
  logic [WID-1:0] dout_d;
  logic [WID-1:0] dout_q;
  logic           underflow_d;
  logic           underflow_q;

  gray_ack_decode #(.WID(WID)) u_decode (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.din),
    .wbin   (wbin),
    .hazard (hazard)
  );

  // dout is recomputed from the next read pointer so it always equals
  // bin2gray(rbin) without a combinational path to the sender.
  always_comb begin
    count       = wbin - rbin_q;
    avail       = (count != '0);
    taken       = bus.consume & avail;
    rbin_d      = rbin_q + WID'(taken);
    dout_d      = WID'(bin2gray(gray_word_t'(rbin_d), WID));
    underflow_d = underflow_q | (bus.consume & ~avail);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rbin_q      <= '0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      dout_q      <= dout_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.avail     = avail;
  assign bus.count     = count;
  assign bus.taken     = taken;
  assign bus.underflow = underflow_q;
  assign bus.hazard    = hazard;

endmodule
`default_nettype wire

// File: tb/tb_gray_ack_return.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_ack_return
// Purpose  : Directed and random checks of gray_ack_return against a queue
//            model of sampled write pointers and a consumed-item counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_ack_return;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  string phase = "init";

  gray_ack_return_if #(.WID(4)) bus ();

  gray_ack_return #(.WID(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: history of write pointers as sampled, read index, flags.
  int unsigned samples[$];
  int unsigned m_r   = 0;
  int unsigned wp    = 0;
  bit          m_under = 1'b0;
  bit          m_haz   = 1'b0;

  function automatic logic [3:0] to_gray(input int unsigned b);
    return 4'((b ^ (b >> 1)) % 16);
  endfunction

  function automatic int unsigned pending();
    return (samples[$] - m_r) % 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic cycle(input int unsigned wnew, input logic cons, input logic rst_i);
    bit exp_taken;
    wp          = wnew % 16;
    reset       = rst_i;
    bus.din     = to_gray(wp);
    bus.consume = cons;
    #1;
    exp_taken = cons && (pending() != 0);
    chk("taken", 32'(bus.taken), 32'(exp_taken));
    @(posedge clk);
    if (rst_i) begin
      samples.delete();
      samples.push_back(0);
      m_r     = 0;
      m_under = 1'b0;
      m_haz   = 1'b0;
    end else begin
      m_haz = (samples.size() >= 2) && (((samples[$] - samples[$-1]) % 16) > 1);
      if (cons) begin
        if (pending() != 0) m_r = (m_r + 1) % 16;
        else                m_under = 1'b1;
      end
      samples.push_back(wp);
      if (samples.size() > 4) void'(samples.pop_front());
    end
    #1;
    chk("count",     32'(bus.count),     32'(pending()));
    chk("avail",     32'(bus.avail),     32'(pending() != 0));
    chk("dout",      32'(bus.dout),      32'(to_gray(m_r)));
    chk("underflow", 32'(bus.underflow), 32'(m_under));
`ifdef GRAY_ACK_HAZARD_EN
    chk("hazard",    32'(bus.hazard),    32'(m_haz));
`else
    chk("hazard",    32'(bus.hazard),    32'(0));
`endif
  endtask

  initial begin
    samples.push_back(0);
    reset       = 1'b1;
    bus.din     = '0;
    bus.consume = 1'b0;

    phase = "reset";
    cycle(0, 1'b0, 1'b1);
    cycle(0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0);

    phase = "single";
    cycle(1, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b0);
    cycle(1, 1'b0, 1'b0);

    // Walk through all gray codes including 15 -> 0, consuming one behind.
    phase = "wrap";
    for (int i = 2; i <= 16; i++) cycle(i, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b0, 1'b0);

    phase = "concurrent";
    for (int i = 1; i <= 5; i++) cycle(i, 1'b0, 1'b0);
    cycle(5, 1'b0, 1'b0);
    cycle(6, 1'b1, 1'b0);
    cycle(6, 1'b0, 1'b0);

    phase = "hazard";
    cycle(0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) cycle(i, 1'b0, 1'b0);
    cycle(3, 1'b0, 1'b0);
    cycle(6, 1'b0, 1'b0);
    cycle(6, 1'b0, 1'b0);
    cycle(6, 1'b0, 1'b0);
    cycle(6, 1'b1, 1'b0);

    phase = "midreset";
    cycle(0, 1'b0, 1'b1);
    cycle(0, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) cycle(i, 1'b0, 1'b0);
    cycle(7, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b1);
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b0, 1'b0);

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      int unsigned step;
      int unsigned pend_drv;
      pend_drv = (wp - m_r) % 16;
      step = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 4) : $urandom_range(0, 1);
      if (pend_drv + step > 15) step = 0;
      if ($urandom_range(0, 79) == 0) begin
        cycle(0, 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        cycle(wp + step, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
